alu_seq: RTL and testbench
==========================

# alu_seq

Sequencing front end for the 8-bit combinational `ALU`. It accepts operation requests over a valid/ready handshake and decodes each opcode into the ALU select lines `s0`–`s4`. It captures the ALU result and carry, and returns the result over a second valid/ready handshake. An 8×8→16 multiply is built as an 8-step shift-add loop on the ALU adder. It sits between the instruction decode stage and the datapath ALU instance, driving every ALU input.

## Interface
- No parameters (data width fixed at 8).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 3: opcode.
- `req_a`, `req_b` in 8: operands.
- `alu_a`, `alu_b` out 8: to ALU `a`, `b`.
- `alu_s0`…`alu_s4` out 1 each: to ALU select lines.
- `alu_z` in 8, `alu_carry` in 1: from ALU.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer accepts.
- `rsp_lo`, `rsp_hi` out 8: result low byte and high byte. `rsp_hi` is 0 except for MUL.
- `rsp_carry` out 1: carry or overflow flag.
- `rsp_zero` out 1: `{rsp_hi,rsp_lo}==0`.
- `rsp_err` out 1: illegal opcode.

## Operation
- ALU select meaning:
  - `{s1,s0}`: 00 = adder sum, 01 = a&b, 10 = a, 11 = b.
  - `s2` = adder carry-in.
  - `s3` = invert b before the adder.
  - `s4=1` forces the adder b-input to 0.
- Opcode decode, as `{s4,s3,s2,s1,s0}`:
  - 000 ADD: 00000.
  - 001 SUB: 01100. `rsp_carry` = no-borrow, so it is 1 when a≥b.
  - 010 AND: 00001.
  - 011 PASSA: 00010.
  - 100 PASSB: 00011.
  - 101 INC: 10100. Result is a+1 and `rsp_carry`=1 when a=0xFF.
  - 110 MUL: multi-cycle.
  - 111: illegal. Returns `rsp_err`=1, all data 0, `rsp_carry`=0, `rsp_zero`=1.
- For logic and pass ops, `rsp_carry` is the ALU `carry_out` value captured at the time.
- States are IDLE, EXEC, MUL, DONE.
  - IDLE: `req_ready`=1. On `req_valid`, latch op, a and b into `op_r`, `a_r`, `b_r`. Go to MUL if op=110; otherwise go to EXEC, including for an illegal op.
  - EXEC (1 cycle): drive `alu_a=a_r`, `alu_b=b_r` and the decoded selects. At the cycle end capture `alu_z`→`rsp_lo` and `alu_carry`→`rsp_carry`. Go to DONE.
  - MUL: on entry `acc=0`, `mq=b_r`, `cnt=0`.
    - Each cycle drive `alu_a=acc`, `alu_b=a_r` and selects ADD. If `mq[0]=0` also set `s4=1`, so the adder adds 0.
    - Update: `acc <= {alu_carry, alu_z[7:1]}`, `mq <= {alu_z[0], mq[7:1]}`, `cnt <= cnt+1`.
    - After 8 steps (at `cnt`=7 the update completes): `rsp_hi=acc`, `rsp_lo=mq`, `rsp_carry=(acc!=0)`. Go to DONE.
  - DONE: `rsp_valid`=1 and all `rsp_*` outputs held stable. On `rsp_ready`, go to IDLE.
- Outside EXEC and MUL, all `alu_*` outputs are 0.

## Timing
- Reset (async, while `rst_n`=0):
  - state=IDLE.
  - `req_ready`=1.
  - `rsp_valid`=0.
  - `rsp_lo`, `rsp_hi`, `rsp_carry`, `rsp_err` = 0.
  - `rsp_zero`=1.
  - all `alu_*` = 0.
  - `cnt`=0.
- Reset asserted mid-EXEC, mid-MUL or in DONE aborts the operation; no response is produced.
- Latency from the accept edge to `rsp_valid` high:
  - Single-cycle ops: 2 cycles (EXEC, then DONE).
  - MUL: 9 cycles (8 MUL steps, then DONE).
- Throughput limits:
  - No overlap between operations. `req_ready`=0 from the cycle after accept until the cycle after the response handshake.
  - Maximum rate is one single-cycle op every 3 cycles with `rsp_ready` tied high.
- `rsp_ready` held low: DONE persists indefinitely with outputs unchanged.
- `rsp_ready` high in a cycle where `rsp_valid`=0 has no effect.
- `req_valid` while `req_ready`=0 is ignored. The requester must hold it until it is accepted.
- ALU path: `alu_*` outputs are combinational from state and registers. The `alu_z`/`alu_carry` path must meet one cycle.

## Test plan
- Reset: assert `rst_n`=0 mid-MUL (cycle 4).
  - Required: immediately `rsp_valid`=0, `alu_*`=0, `req_ready`=1.
  - Required: after release, a new ADD completes normally.
- ADD 0xF0+0x20.
  - Required: `rsp_lo`=0x10, `rsp_carry`=1, `rsp_zero`=0, `rsp_valid` 2 cycles after accept.
- SUB 0x05−0x05 → `rsp_lo`=0x00, `rsp_carry`=1, `rsp_zero`=1.
- SUB 0x03−0x04 → `rsp_lo`=0xFF, `rsp_carry`=0.
- INC 0xFF → `rsp_lo`=0x00, `rsp_carry`=1.
- AND 0xCA&0x0F → `rsp_lo`=0x0A.
- MUL 0xFF×0xFF.
  - Required: `{rsp_hi,rsp_lo}`=0xFE01, `rsp_carry`=1, `rsp_valid` exactly 9 cycles after accept.
- MUL 0x0C×0x0A → 0x0078 with `rsp_carry`=0.
- MUL 0x00×0x37 → `rsp_zero`=1.
- Backpressure on opcode 111: hold `rsp_ready`=0 for 5 cycles.
  - Required: `rsp_err`=1 and all outputs stable.
  - Required: `req_ready`=0 throughout, and a `req_valid` pulse during the stall is not accepted.

Source files
------------

// File: rtl/alu_seq.sv
// Sequencing front end for an 8-bit combinational ALU.
// Decodes opcodes to ALU selects and runs an 8-step shift-add multiply.
module alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_s0,
  output logic       alu_s1,
  output logic       alu_s2,
  output logic       alu_s3,
  output logic       alu_s4,
  input  logic [7:0] alu_z,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_lo,
  output logic [7:0] rsp_hi,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_PSA = 3'b011;
  localparam logic [2:0] OP_PSB = 3'b100;
  localparam logic [2:0] OP_INC = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] mq_q, mq_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;
  logic       cy_q, cy_d;
  logic       err_q, err_d;
  logic [4:0] sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= 8'd0;
      mq_q    <= 8'd0;
      cnt_q   <= 3'd0;
      lo_q    <= 8'd0;
      hi_q    <= 8'd0;
      cy_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cy_q    <= cy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (req_op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: state_d = S_DONE;
      S_MUL: begin
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    mq_d  = mq_q;
    cnt_d = cnt_q;
    lo_d  = lo_q;
    hi_d  = hi_q;
    cy_d  = cy_q;
    err_d = err_q;
    if (state_q == S_IDLE && req_valid) begin
      op_d  = req_op;
      a_d   = req_a;
      b_d   = req_b;
      acc_d = 8'd0;
      mq_d  = req_b;
      cnt_d = 3'd0;
    end
    if (state_q == S_EXEC) begin
      err_d = (op_q == OP_ILL);
      hi_d  = 8'd0;
      lo_d  = err_d ? 8'd0 : alu_z;
      cy_d  = err_d ? 1'b0 : alu_carry;
    end
    // One shift-add step: 9-bit sum shifts right across acc:mq
    if (state_q == S_MUL) begin
      acc_d = {alu_carry, alu_z[7:1]};
      mq_d  = {alu_z[0], mq_q[7:1]};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        hi_d  = acc_d;
        lo_d  = mq_d;
        cy_d  = |acc_d;
        err_d = 1'b0;
      end
    end
  end

  always_comb begin
    alu_a = 8'd0;
    alu_b = 8'd0;
    sel   = 5'b00000;
    if (state_q == S_EXEC) begin
      alu_a = a_q;
      alu_b = b_q;
      unique case (1'b1)
        (op_q == OP_ADD): sel = 5'b00000;
        (op_q == OP_SUB): sel = 5'b01100;
        (op_q == OP_AND): sel = 5'b00001;
        (op_q == OP_PSA): sel = 5'b00010;
        (op_q == OP_PSB): sel = 5'b00011;
        (op_q == OP_INC): sel = 5'b10100;
        default:          sel = 5'b00000;
      endcase
    end else if (state_q == S_MUL) begin
      alu_a = acc_q;
      alu_b = a_q;
      sel   = {~mq_q[0], 4'b0000};
    end
  end

  assign alu_s0    = sel[0];
  assign alu_s1    = sel[1];
  assign alu_s2    = sel[2];
  assign alu_s3    = sel[3];
  assign alu_s4    = sel[4];
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_lo    = lo_q;
  assign rsp_hi    = hi_q;
  assign rsp_carry = cy_q;
  assign rsp_zero  = ({hi_q, lo_q} == 16'd0);
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU plus arithmetic reference model,
// directed corner cases followed by random operations.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic [7:0] req_a = 8'd0;
  logic [7:0] req_b = 8'd0;
  logic [7:0] alu_a, alu_b;
  logic       alu_s0, alu_s1, alu_s2, alu_s3, alu_s4;
  logic [7:0] alu_z;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_lo, rsp_hi;
  logic       rsp_carry, rsp_zero, rsp_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s0    (alu_s0),
    .alu_s1    (alu_s1),
    .alu_s2    (alu_s2),
    .alu_s3    (alu_s3),
    .alu_s4    (alu_s4),
    .alu_z     (alu_z),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_lo    (rsp_lo),
    .rsp_hi    (rsp_hi),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err)
  );

  // Combinational ALU the sequencer drives
  always_comb begin
    logic [7:0] bb;
    logic [8:0] sum;
    bb = alu_s4 ? 8'd0 : (alu_s3 ? ~alu_b : alu_b);
    sum = {1'b0, alu_a} + {1'b0, bb} + {8'd0, alu_s2};
    alu_carry = sum[8];
    case ({alu_s1, alu_s0})
      2'b00:   alu_z = sum[7:0];
      2'b01:   alu_z = alu_a & alu_b;
      2'b10:   alu_z = alu_a;
      default: alu_z = alu_b;
    endcase
  end

  typedef struct packed {
    logic        err;
    logic        c;
    logic [15:0] p;
  } exp_t;

  function automatic exp_t ref_op(input logic [2:0] op,
                                  input logic [7:0] a,
                                  input logic [7:0] b);
    exp_t e;
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    e = '0;
    case (op)
      3'd0: begin r = ai + bi; e.p = 16'(r % 256); e.c = r > 255; end
      3'd1: begin r = (ai - bi + 256) % 256; e.p = 16'(r); e.c = ai >= bi; end
      3'd2: begin e.p = {8'd0, a & b}; e.c = (ai + bi) > 255; end
      3'd3: begin e.p = {8'd0, a}; e.c = (ai + bi) > 255; end
      3'd4: begin e.p = {8'd0, b}; e.c = (ai + bi) > 255; end
      3'd5: begin e.p = 16'((ai + 1) % 256); e.c = ai == 255; end
      3'd6: begin r = ai * bi; e.p = 16'(r); e.c = r > 255; end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input exp_t e);
    chk("rsp_lo", 16'(rsp_lo), 16'(e.p[7:0]));
    chk("rsp_hi", 16'(rsp_hi), 16'(e.p[15:8]));
    chk("rsp_carry", 16'(rsp_carry), 16'(e.c));
    chk("rsp_zero", 16'(rsp_zero), 16'(e.p == 16'd0));
    chk("rsp_err", 16'(rsp_err), 16'(e.err));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int stall);
    exp_t e;
    int lat;
    e = ref_op(op, a, b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    chk("req_ready_idle", 16'(req_ready), 16'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    chk("req_ready_busy", 16'(req_ready), 16'd0);
    if (op == 3'd6) begin
      chk("mul_alu_a", 16'(alu_a), 16'd0);
      chk("mul_alu_b", 16'(alu_b), 16'(a));
    end else if (op != 3'd7) begin
      chk("exec_alu_a", 16'(alu_a), 16'(a));
      chk("exec_alu_b", 16'(alu_b), 16'(b));
    end
    while (!rsp_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 16'(lat), (op == 3'd6) ? 16'd9 : 16'd2);
    check_rsp(e);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      chk("stall_valid", 16'(rsp_valid), 16'd1);
      check_rsp(e);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("req_ready_after", 16'(req_ready), 16'd1);
    chk("rsp_valid_after", 16'(rsp_valid), 16'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_req_ready", 16'(req_ready), 16'd1);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rsp_data", {rsp_hi, rsp_lo}, 16'd0);
    chk("rst_rsp_flags", {13'd0, rsp_carry, rsp_err, rsp_zero}, 16'd1);
    chk("rst_alu", {alu_a, alu_b}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the 4th MUL cycle aborts the multiply
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd6;
    req_a = 8'hFF;
    req_b = 8'h03;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("abort_alu_ab", {alu_a, alu_b}, 16'd0);
    chk("abort_alu_sel",
        {11'd0, alu_s4, alu_s3, alu_s2, alu_s1, alu_s0}, 16'd0);
    chk("abort_req_ready", 16'(req_ready), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_rsp", 16'(rsp_valid), 16'd0);
    run_op(3'd0, 8'h11, 8'h22, 0);

    // Directed cases
    run_op(3'd0, 8'hF0, 8'h20, 0);
    run_op(3'd1, 8'h05, 8'h05, 0);
    run_op(3'd1, 8'h03, 8'h04, 0);
    run_op(3'd5, 8'hFF, 8'h00, 0);
    run_op(3'd2, 8'hCA, 8'h0F, 0);
    run_op(3'd3, 8'hA5, 8'h7E, 1);
    run_op(3'd4, 8'hA5, 8'h7E, 0);
    run_op(3'd6, 8'hFF, 8'hFF, 0);
    run_op(3'd6, 8'h0C, 8'h0A, 2);
    run_op(3'd6, 8'h00, 8'h37, 0);

    // Illegal op under backpressure, with a stray request mid-stall
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd7;
    req_a = 8'h5A;
    req_b = 8'hC3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i == 2);
      req_op = 3'd0;
      req_a = 8'h01;
      req_b = 8'h01;
      @(posedge clk);
      #1;
      chk("bp_rsp_valid", 16'(rsp_valid), 16'd1);
      chk("bp_req_ready", 16'(req_ready), 16'd0);
      chk("bp_rsp_data", {rsp_hi, rsp_lo}, 16'd0);
      chk("bp_rsp_flags", {13'd0, rsp_carry, rsp_err, rsp_zero}, 16'd3);
    end
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_stray_valid", 16'(rsp_valid), 16'd0);
    chk("bp_idle_ready", 16'(req_ready), 16'd1);

    // Random operations
    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
